// File: rtl/freelist_ctrl_if.sv
// rtl/freelist_ctrl_if.sv - rename/retire handshake bundle for the physical-register free list
interface freelist_ctrl_if #(
  parameter int PREG       = 6,
  parameter int DECODE_NUM = 4,
  parameter int RETIRE_NUM = 4
);
  logic                       alloc_valid;
  logic [DECODE_NUM-1:0]      alloc_req;
  logic                       alloc_ready;
  logic [DECODE_NUM*PREG-1:0] alloc_preg;
  logic [RETIRE_NUM-1:0]      rel_v;
  logic [RETIRE_NUM*PREG-1:0] rel_preg;
  logic [PREG:0]              free_count;
  logic                       overflow_err;

  // Rename/ROB side drives requests and releases
  modport master (
    output alloc_valid, alloc_req, rel_v, rel_preg,
    input  alloc_ready, alloc_preg, free_count, overflow_err
  );

  // Free list side serves grants and reports occupancy
  modport slave (
    input  alloc_valid, alloc_req, rel_v, rel_preg,
    output alloc_ready, alloc_preg, free_count, overflow_err
  );
endinterface

// File: rtl/freelist_ctrl.sv
// rtl/freelist_ctrl.sv - circular FIFO of free physical register IDs between rename and retire
module freelist_ctrl #(
  parameter int PREG       = 6,
  parameter int NUM_PREG   = 64,
  parameter int NUM_AREG   = 32,
  parameter int DECODE_NUM = 4,
  parameter int RETIRE_NUM = 4
) (
  input logic              clk,
  input logic              rst,
  freelist_ctrl_if.slave   fl
);

  // Wide enough to hold NUM_PREG plus a full release group without wrapping
  localparam int CW = PREG + 2;

  logic [PREG-1:0] fifo_q [NUM_PREG];
  logic [PREG-1:0] head_q, head_d;
  logic [PREG-1:0] tail_q, tail_d;
  logic [PREG:0]   count_q, count_d;
  logic            ovf_q, ovf_d;

  logic [CW-1:0]              n_alloc;
  logic [CW-1:0]              n_rel;
  logic [CW-1:0]              taken;
  logic [CW-1:0]              cnt_after;
  logic                       ready;
  logic                       fire;
  logic                       rel_commit;
  logic [DECODE_NUM*PREG-1:0] grant;
  logic [RETIRE_NUM-1:0]      rel_eff;
  logic [PREG-1:0]            wr_idx [RETIRE_NUM];

  // Compacted grant: each requesting slot takes the next free ID after those given to lower slots
  always_comb begin
    n_alloc = '0;
    grant   = '0;
    for (int i = 0; i < DECODE_NUM; i++) begin
      if (fl.alloc_req[i]) begin
        grant[i*PREG +: PREG] = fifo_q[head_q + n_alloc[PREG-1:0]];
        n_alloc = n_alloc + CW'(1);
      end
    end
    ready = !rst && ({1'b0, count_q} >= n_alloc);
    if (rst) begin
      grant = '0;
    end
  end

  // Compacted release: preg 0 is the hard-wired x0 mapping and is never put back
  always_comb begin
    n_rel = '0;
    for (int j = 0; j < RETIRE_NUM; j++) begin
      rel_eff[j] = fl.rel_v[j] && (fl.rel_preg[j*PREG +: PREG] != '0);
      wr_idx[j]  = tail_q + n_rel[PREG-1:0];
      if (rel_eff[j]) begin
        n_rel = n_rel + CW'(1);
      end
    end
  end

  // Next-state pointers and occupancy; a release that would exceed capacity is dropped whole
  always_comb begin
    fire       = fl.alloc_valid && ready;
    taken      = fire ? n_alloc : '0;
    cnt_after  = {1'b0, count_q} - taken + n_rel;
    rel_commit = (cnt_after <= CW'(NUM_PREG));
    head_d     = fire ? head_q + n_alloc[PREG-1:0] : head_q;
    tail_d     = rel_commit ? tail_q + n_rel[PREG-1:0] : tail_q;
    count_d    = rel_commit ? cnt_after[PREG:0] : count_q - taken[PREG:0];
    ovf_d      = ovf_q | ~rel_commit;
  end

  // State update; reset preloads the unmapped pregs and overrides any same-cycle traffic
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_PREG; k++) begin
        fifo_q[k] <= (k < NUM_PREG - NUM_AREG) ? PREG'(NUM_AREG + k) : '0;
      end
      head_q  <= '0;
      tail_q  <= PREG'(NUM_PREG - NUM_AREG);
      count_q <= (PREG+1)'(NUM_PREG - NUM_AREG);
      ovf_q   <= 1'b0;
    end else begin
      if (rel_commit) begin
        for (int j = 0; j < RETIRE_NUM; j++) begin
          if (rel_eff[j]) begin
            fifo_q[wr_idx[j]] <= fl.rel_preg[j*PREG +: PREG];
          end
        end
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign fl.alloc_ready  = ready;
  assign fl.alloc_preg   = grant;
  assign fl.free_count   = count_q;
  assign fl.overflow_err = ovf_q;

endmodule

// File: tb/tb_freelist_ctrl.sv
// tb/tb_freelist_ctrl.sv - directed self-checking bench for freelist_ctrl
module tb_freelist_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  freelist_ctrl_if #(.PREG(6), .DECODE_NUM(4), .RETIRE_NUM(4)) fl ();

  freelist_ctrl #(
    .PREG(6), .NUM_PREG(64), .NUM_AREG(32), .DECODE_NUM(4), .RETIRE_NUM(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fl (fl)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] slot(input int i);
    return fl.alloc_preg[i*6 +: 6];
  endfunction

  task automatic drive(input logic v, input logic [3:0] req, input logic [3:0] rv,
                       input logic [5:0] p3, input logic [5:0] p2,
                       input logic [5:0] p1, input logic [5:0] p0);
    fl.alloc_valid = v;
    fl.alloc_req   = req;
    fl.rel_v       = rv;
    fl.rel_preg    = {p3, p2, p1, p0};
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 4'b0000, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b1, 4'b1111, 4'b1111, 6'd9, 6'd8, 6'd7, 6'd6);
    chk("rst_ready", fl.alloc_ready, 0);
    chk("rst_preg", fl.alloc_preg, 0);
    tick();
    rst = 1'b0;
    idle();
    chk("rst_free", fl.free_count, 32);
    chk("rst_ovf", fl.overflow_err, 0);
  endtask

  initial begin
    idle();
    tick();
    do_reset();

    // Full group from reset
    drive(1'b1, 4'b1111, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0);
    chk("g4_ready", fl.alloc_ready, 1);
    chk("g4_s0", slot(0), 32);
    chk("g4_s1", slot(1), 33);
    chk("g4_s2", slot(2), 34);
    chk("g4_s3", slot(3), 35);
    tick();
    idle();
    chk("g4_free", fl.free_count, 28);

    // Sparse group is compacted
    do_reset();
    drive(1'b1, 4'b1010, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0);
    chk("sp_s0", slot(0), 0);
    chk("sp_s1", slot(1), 32);
    chk("sp_s2", slot(2), 0);
    chk("sp_s3", slot(3), 33);
    tick();
    idle();
    chk("sp_free", fl.free_count, 30);

    // Drain to empty
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, 4'b1111, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0);
      if (c == 7) begin
        chk("dr_s0", slot(0), 60);
        chk("dr_s3", slot(3), 63);
      end
      tick();
    end
    idle();
    chk("dr_free", fl.free_count, 0);
    drive(1'b1, 4'b0001, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0);
    chk("empty_ready", fl.alloc_ready, 0);
    tick();
    chk("empty_hold", fl.free_count, 0);
    drive(1'b1, 4'b0000, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0);
    chk("zero_ready", fl.alloc_ready, 1);
    tick();

    // Release at empty is not visible to same-cycle allocation
    drive(1'b1, 4'b0001, 4'b0011, 6'd0, 6'd0, 6'd41, 6'd40);
    chk("nobyp_ready", fl.alloc_ready, 0);
    tick();
    drive(1'b1, 4'b0001, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0);
    chk("nobyp_free", fl.free_count, 2);
    chk("nobyp_ready2", fl.alloc_ready, 1);
    chk("nobyp_s0", slot(0), 40);
    tick();
    idle();
    chk("nobyp_free2", fl.free_count, 1);

    // Preg 0 in a release group is skipped
    drive(1'b0, 4'b0000, 4'b1111, 6'd0, 6'd50, 6'd0, 6'd51);
    tick();
    idle();
    chk("p0_free", fl.free_count, 3);
    drive(1'b1, 4'b1111, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0);
    chk("p0_short", fl.alloc_ready, 0);
    drive(1'b1, 4'b0111, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0);
    chk("p0_s0", slot(0), 41);
    chk("p0_s1", slot(1), 51);
    chk("p0_s2", slot(2), 50);
    chk("p0_s3", slot(3), 0);
    tick();
    idle();
    chk("p0_free2", fl.free_count, 0);

    // Fill to capacity, then overflow
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, 4'b0000, 4'b1111, 6'(4*c+4), 6'(4*c+3), 6'(4*c+2), 6'(4*c+1));
      tick();
    end
    idle();
    chk("full_free", fl.free_count, 64);
    chk("full_ovf", fl.overflow_err, 0);
    drive(1'b0, 4'b0000, 4'b1111, 6'd63, 6'd62, 6'd61, 6'd60);
    tick();
    idle();
    chk("ovf_free", fl.free_count, 64);
    chk("ovf_flag", fl.overflow_err, 1);
    drive(1'b1, 4'b1111, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0);
    chk("ovf_s0", slot(0), 32);
    chk("ovf_s3", slot(3), 35);
    tick();
    idle();
    chk("ovf_sticky", fl.overflow_err, 1);
    chk("ovf_free2", fl.free_count, 60);
    do_reset();

    // Wrap: shift head by 2, then run alloc+release in lockstep until head sits at 62
    drive(1'b1, 4'b0011, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0);
    tick();
    for (int c = 0; c < 15; c++) begin
      drive(1'b1, 4'b1111, 4'b1111, 6'(4*c+4), 6'(4*c+3), 6'(4*c+2), 6'(4*c+1));
      tick();
    end
    idle();
    chk("wr_free", fl.free_count, 30);
    drive(1'b1, 4'b1111, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0);
    chk("wr_s0", slot(0), 31);
    chk("wr_s1", slot(1), 32);
    chk("wr_s2", slot(2), 33);
    chk("wr_s3", slot(3), 34);
    tick();
    idle();
    chk("wr_free2", fl.free_count, 26);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/freelist_ctrl.md
Name: freelist_ctrl

Overview:
- Physical-register free list controller between rename and retire.
- Hands out up to DECODE_NUM free physical destination registers per cycle to the rename slots.
- Takes back up to RETIRE_NUM old physical registers (opreg) per cycle from ROB retirement.
- Storage is a circular FIFO of free preg IDs with head/tail pointers and an occupancy counter; rename stalls when the whole group cannot be served.

Parameters:
- PREG, 6, physical register ID width.
- NUM_PREG, 64, number of physical registers (2**PREG).
- NUM_AREG, 32, architectural registers; pregs 0..NUM_AREG-1 are mapped at reset.
- DECODE_NUM, 4, allocation slots per cycle.
- RETIRE_NUM, 4, release slots per cycle.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- alloc_valid  in  1  rename group present this cycle.
- alloc_req  in  DECODE_NUM  per-slot "needs a dest preg" (areg_v && areg!=0).
- alloc_ready  out  1  whole group can be served.
- alloc_preg  out  DECODE_NUM*PREG  slot i's preg at bits [i*PREG +: PREG]; 0 for non-requesting slots.
- rel_v  in  RETIRE_NUM  per-slot release valid (retiring instr with areg_v).
- rel_preg  in  RETIRE_NUM*PREG  released old pregs, packed as alloc_preg.
- free_count  out  PREG+1  current number of free entries.
- overflow_err  out  1  sticky: release attempted beyond capacity.

Behaviour:
- FIFO: NUM_PREG entries × PREG bits, head (read) and tail (write) pointers of PREG bits, wrapping mod NUM_PREG. count is PREG+1 bits.
- Reset (sync, rst=1 at posedge):
  - entry k = NUM_AREG+k for k=0..NUM_PREG-NUM_AREG-1.
  - head=0, tail=NUM_PREG-NUM_AREG (32), count=32, free_count=32, overflow_err=0.
  - While rst=1, alloc_ready=0 and alloc_preg=0.
- Allocation (combinational grant, registered update):
  - n_alloc = popcount(alloc_req).
  - alloc_ready = !rst && (count >= n_alloc).
  - Slot i receives fifo[head + k_i], where k_i = popcount(alloc_req[i-1:0]). The compaction means requesting slots get consecutive free IDs in slot order.
  - fire = alloc_valid && alloc_ready. On fire, head += n_alloc at the next posedge.
  - All-or-nothing: there are no partial grants. When not ready, head and count are unchanged and decode must hold the group.
  - n_alloc=0 is always ready and does not move head.
- Release:
  - Effective slot j = rel_v[j] && rel_preg[j]!=0. Preg 0 (x0 mapping) is never returned.
  - n_rel = effective count. Effective entries are written compacted, in slot order, at tail, tail+1, …; tail += n_rel.
  - No backpressure on release.
- Simultaneous events:
  - count_next = count − (fire ? n_alloc : 0) + n_rel.
  - Pregs released in cycle T are not allocatable until T+1 (no bypass). The alloc_ready check uses the pre-update count.
- Overflow:
  - If count − alloc_taken + n_rel > NUM_PREG, the release is dropped: tail and count are not advanced by n_rel, and overflow_err is set.
  - overflow_err clears only on rst.
- Wrap-around: pointer arithmetic is modulo NUM_PREG. Head/tail crossing 63→0 within one group must index correctly.
- free_count equals the count register (registered, updated each posedge).
- Reset mid-operation: rst overrides alloc/release in the same cycle, and all state returns to reset values.

Test Plan:
- Reset, then alloc_valid=1, alloc_req=4'b1111 → alloc_ready=1, alloc_preg = {35,34,33,32} (slot3..slot0); next cycle free_count=28.
- alloc_req=4'b1010 from reset state → slot1=32, slot3=33, slots0/2=0; free_count 32→30.
- Drain: 8 fires of 4'b1111 → free_count=0. Then alloc_req=4'b0001 → alloc_ready=0, head unchanged. alloc_req=0 → alloc_ready=1.
- Same cycle at free_count=0: rel_v=4'b0011, rel_preg slots = {40,41}, plus alloc_req=4'b0001 → alloc_ready=0. Next cycle free_count=2 and alloc_req=4'b0001 grants 40.
- rel_v=4'b1111 with rel_preg slots {0,50,0,51} → only 50, 51 written; free_count +2.
- From reset (free_count=32), release 4 IDs per cycle for 8 cycles → free_count=64. A 9th release → dropped, overflow_err=1, free_count stays 64. Then rst → overflow_err=0, free_count=32.
- Wrap: cycle head past 63 by repeated alloc/release; a group spanning index 63→0 returns the correct consecutive IDs.
